// File: rtl/disk_controller_sd_cmd_if.sv
// Byte-exchange handshake between the SD command sequencer and the SPI shift engine.
// The sequencer is the master: it owns the outgoing byte and the strobe.
interface disk_controller_sd_cmd_if;
    logic [7:0] spi_dat_o;
    logic [7:0] spi_dat_i;
    logic       spi_strobe_o;
    logic       spi_busy_i;

    modport master (
        output spi_dat_o,
        output spi_strobe_o,
        input  spi_dat_i,
        input  spi_busy_i
    );

    modport slave (
        input  spi_dat_o,
        input  spi_strobe_o,
        output spi_dat_i,
        output spi_busy_i
    );
endinterface

// File: rtl/disk_controller_sd_cmd.sv
// SD-card command sequencer (SPI mode): frames CMD+CRC7, polls R1,
// optionally waits for a start token and streams one data block.
module disk_controller_sd_cmd #(
    parameter int RESP_TRIES  = 8,
    parameter int TOKEN_TRIES = 2048,
    parameter int BLOCK_BYTES = 512
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [5:0]  cmd_i,
    input  logic [31:0] arg_i,
    input  logic        read_block_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [7:0]  r1_o,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic        cs_no,
    disk_controller_sd_cmd_if.master spi
);
    localparam int MAXA = (RESP_TRIES > TOKEN_TRIES) ? RESP_TRIES : TOKEN_TRIES;
    localparam int MAXB = (MAXA > BLOCK_BYTES) ? MAXA : BLOCK_BYTES;
    localparam int MAXN = (MAXB > 6) ? MAXB : 6;
    localparam int CW   = $clog2(MAXN + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STB, S_GAP, S_WAIT} state_t;
    typedef enum logic [2:0] {P_CMD, P_RESP, P_TOKEN, P_DATA, P_CRC, P_TAIL} phase_t;

    function automatic logic [6:0] crc7_upd(input logic [6:0] c, input logic [7:0] b);
        logic [6:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[6] ^ b[i];
            r  = {r[5:0], 1'b0};
            if (fb) r = r ^ 7'h09;
        end
        return r;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [5:0] c,
                                              input logic [31:0] a, input logic [6:0] crc);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {2'b01, c};
            3'd1:    b = a[31:24];
            3'd2:    b = a[23:16];
            3'd3:    b = a[15:8];
            3'd4:    b = a[7:0];
            default: b = {crc, 1'b1};
        endcase
        return b;
    endfunction

    state_t      r_state;
    phase_t      r_phase;
    logic [CW-1:0] r_cnt;
    logic [5:0]  r_cmd;
    logic [31:0] r_arg;
    logic        r_rd;
    logic [6:0]  r_crc;
    logic        r_busy, r_done, r_dv, r_cs_n, r_stb;
    logic [1:0]  r_status;
    logic [7:0]  r_r1, r_data, r_spi_dat;

    logic [2:0]  w_idx;
    logic [7:0]  w_frame0, w_frame, w_rx;

    assign w_idx    = r_cnt[2:0] + 3'd1;
    assign w_frame0 = frame_byte(3'd0, r_cmd, r_arg, r_crc);
    assign w_frame  = frame_byte(w_idx, r_cmd, r_arg, r_crc);
    assign w_rx     = spi.spi_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_phase   <= P_CMD;
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_arg     <= '0;
            r_rd      <= 1'b0;
            r_crc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dv      <= 1'b0;
            r_cs_n    <= 1'b1;
            r_stb     <= 1'b0;
            r_status  <= 2'd0;
            r_r1      <= 8'hFF;
            r_data    <= 8'h00;
            r_spi_dat <= 8'hFF;
        end else begin
            r_done <= 1'b0;
            r_dv   <= 1'b0;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_cmd    <= cmd_i;
                    r_arg    <= arg_i;
                    r_rd     <= read_block_i;
                    r_busy   <= 1'b1;
                    r_cs_n   <= 1'b0;
                    r_crc    <= '0;
                    r_status <= 2'd0;
                    r_r1     <= 8'hFF;
                    r_phase  <= P_CMD;
                    r_cnt    <= '0;
                    r_state  <= S_LOAD;
                end
                S_LOAD: begin
                    r_spi_dat <= w_frame0;
                    r_crc     <= crc7_upd(r_crc, w_frame0);
                    r_stb     <= 1'b1;
                    r_state   <= S_STB;
                end
                S_STB: begin
                    r_stb   <= 1'b0;
                    r_state <= S_GAP;
                end
                // engine raises busy one cycle late, so this cycle is ignored
                S_GAP: r_state <= S_WAIT;
                S_WAIT: if (!spi.spi_busy_i) begin
                    r_state   <= S_STB;
                    r_stb     <= 1'b1;
                    r_spi_dat <= 8'hFF;
                    r_cnt     <= r_cnt + 1'b1;
                    case (r_phase)
                        P_CMD: begin
                            if (r_cnt == CW'(5)) begin
                                r_phase <= P_RESP;
                                r_cnt   <= '0;
                            end else begin
                                r_spi_dat <= w_frame;
                                if (w_idx != 3'd5) r_crc <= crc7_upd(r_crc, w_frame);
                            end
                        end
                        P_RESP: begin
                            if (!w_rx[7]) begin
                                r_r1 <= w_rx;
                                if (r_rd && w_rx == 8'h00) begin
                                    r_phase <= P_TOKEN;
                                    r_cnt   <= '0;
                                end else begin
                                    r_phase  <= P_TAIL;
                                    r_cs_n   <= 1'b1;
                                    r_status <= 2'd0;
                                end
                            end else if (r_cnt == CW'(RESP_TRIES - 1)) begin
                                r_phase  <= P_TAIL;
                                r_cs_n   <= 1'b1;
                                r_status <= 2'd1;
                            end
                        end
                        P_TOKEN: begin
                            if (w_rx == 8'hFE) begin
                                r_phase <= P_DATA;
                                r_cnt   <= '0;
                            end else if (w_rx[7:4] == 4'h0) begin
                                r_r1     <= w_rx;
                                r_phase  <= P_TAIL;
                                r_cs_n   <= 1'b1;
                                r_status <= 2'd3;
                            end else if (r_cnt == CW'(TOKEN_TRIES - 1)) begin
                                r_phase  <= P_TAIL;
                                r_cs_n   <= 1'b1;
                                r_status <= 2'd2;
                            end
                        end
                        P_DATA: begin
                            r_data <= w_rx;
                            r_dv   <= 1'b1;
                            if (r_cnt == CW'(BLOCK_BYTES - 1)) begin
                                r_phase <= P_CRC;
                                r_cnt   <= '0;
                            end
                        end
                        P_CRC: begin
                            if (r_cnt == CW'(1)) begin
                                r_phase  <= P_TAIL;
                                r_cs_n   <= 1'b1;
                                r_status <= 2'd0;
                            end
                        end
                        default: begin
                            r_stb   <= 1'b0;
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign status_o         = r_status;
    assign r1_o             = r_r1;
    assign data_o           = r_data;
    assign data_valid_o     = r_dv;
    assign cs_no            = r_cs_n;
    assign spi.spi_dat_o    = r_spi_dat;
    assign spi.spi_strobe_o = r_stb;
endmodule

// File: tb/tb_disk_controller_sd_cmd.sv
// Bench for disk_controller_sd_cmd: SPI engine + SD card model, and a
// transaction-level reference built directly from the command protocol.
module tb_disk_controller_sd_cmd;
    localparam int RESP_TRIES  = 8;
    localparam int TOKEN_TRIES = 2048;
    localparam int BLOCK_BYTES = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cmd = '0;
    logic [31:0] arg = '0;
    logic        rd = 1'b0;
    logic        busy, done, dv, cs_n;
    logic [1:0]  status;
    logic [7:0]  r1, data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] resp_q[$];
    logic [8:0] mosi_q[$];
    logic [7:0] dq[$];

    always #5 clk = ~clk;

    disk_controller_sd_cmd_if sif();

    disk_controller_sd_cmd dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cmd_i(cmd), .arg_i(arg),
        .read_block_i(rd), .busy_o(busy), .done_o(done), .status_o(status),
        .r1_o(r1), .data_o(data), .data_valid_o(dv), .cs_no(cs_n), .spi(sif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // shift engine + card: busy rises a cycle after strobe, lasts 1..3 cycles
    initial begin
        sif.spi_busy_i = 1'b0;
        sif.spi_dat_i  = 8'hFF;
        forever begin
            @(negedge clk);
            if (rst_n && sif.spi_strobe_o === 1'b1) begin
                mosi_q.push_back({cs_n, sif.spi_dat_o});
                @(negedge clk);
                sif.spi_busy_i = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                sif.spi_busy_i = 1'b0;
                sif.spi_dat_i  = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                chk("done_busy_fall", busy, 1'b0);
            end
            if (dv) dq.push_back(data);
            if (sif.spi_strobe_o) chk("strobe_vs_busy", sif.spi_busy_i, 1'b0);
        end
    end

    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] v;
        v = {msg, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic logic [7:0] card(input logic [7:0] rep[$], inout int p);
        logic [7:0] b;
        b = (p < rep.size()) ? rep[p] : 8'hFF;
        p++;
        return b;
    endfunction

    function automatic void model(input logic [5:0] c, input logic [31:0] a, input logic r,
                                  input logic [7:0] rep[$], output logic [8:0] em[$],
                                  output logic [7:0] ed[$], output logic [1:0] st,
                                  output logic [7:0] er1);
        logic [39:0] msg;
        logic [7:0]  b;
        int          p;
        bit          found, tok;
        msg = {2'b01, c, a};
        em = {};
        ed = {};
        for (int i = 0; i < 5; i++) em.push_back({1'b0, msg[39 - 8 * i -: 8]});
        em.push_back({1'b0, crc7_ref(msg), 1'b1});
        p = 0; er1 = 8'hFF; st = 2'd1; found = 0; tok = 0;
        for (int k = 0; k < RESP_TRIES; k++) begin
            em.push_back(9'h0FF);
            b = card(rep, p);
            if (!b[7]) begin er1 = b; found = 1; break; end
        end
        if (found) begin
            st = 2'd0;
            if (r && er1 == 8'h00) begin
                st = 2'd2;
                for (int k = 0; k < TOKEN_TRIES; k++) begin
                    em.push_back(9'h0FF);
                    b = card(rep, p);
                    if (b == 8'hFE) begin tok = 1; break; end
                    if (b < 8'h10) begin er1 = b; st = 2'd3; break; end
                end
                if (tok) begin
                    for (int k = 0; k < BLOCK_BYTES; k++) begin
                        em.push_back(9'h0FF);
                        ed.push_back(card(rep, p));
                    end
                    em.push_back(9'h0FF);
                    em.push_back(9'h0FF);
                    st = 2'd0;
                end
            end
        end
        em.push_back(9'h1FF);
    endfunction

    task automatic run(input logic [5:0] c, input logic [31:0] a, input logic r,
                       input logic [7:0] rep[$], input bit glitch);
        logic [8:0] em[$];
        logic [7:0] ed[$];
        logic [1:0] es;
        logic [7:0] er1;
        int n;
        resp_q = {};
        repeat (6) resp_q.push_back(8'hFF);
        foreach (rep[i]) resp_q.push_back(rep[i]);
        mosi_q = {}; dq = {}; done_cnt = 0;
        model(c, a, r, rep, em, ed, es, er1);
        @(negedge clk);
        start = 1'b1; cmd = c; arg = a; rd = r;
        @(negedge clk);
        start = 1'b0; cmd = 6'($urandom); arg = $urandom; rd = ~r;
        chk("busy_latency", busy, 1'b1);
        chk("cs_latency", cs_n, 1'b0);
        chk("strobe_early", sif.spi_strobe_o, 1'b0);
        @(negedge clk);
        chk("strobe_latency", sif.spi_strobe_o, 1'b1);
        if (glitch) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt != 0, 1'b1);
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("status", status, es);
        chk("r1", r1, er1);
        chk("busy_end", busy, 1'b0);
        chk("cs_end", cs_n, 1'b1);
        chk("mosi_len", mosi_q.size(), em.size());
        for (int i = 0; i < em.size(); i++)
            if (i < mosi_q.size()) chk($sformatf("mosi[%0d]", i), mosi_q[i], em[i]);
        chk("data_len", dq.size(), ed.size());
        for (int i = 0; i < ed.size(); i++)
            if (i < dq.size()) chk($sformatf("data[%0d]", i), dq[i], ed[i]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_status"}, status, 2'd0);
        chk({tag, "_r1"}, r1, 8'hFF);
        chk({tag, "_data"}, data, 8'h00);
        chk({tag, "_dv"}, dv, 1'b0);
        chk({tag, "_cs"}, cs_n, 1'b1);
        chk({tag, "_spidat"}, sif.spi_dat_o, 8'hFF);
        chk({tag, "_strobe"}, sif.spi_strobe_o, 1'b0);
    endtask

    initial begin
        logic [7:0] rep[$];
        logic [7:0] v;
        logic       rr;
        int         n;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        rep = '{8'hFF, 8'hFF, 8'h01};
        run(6'd0, 32'h0, 1'b0, rep, 1'b0);
        if (mosi_q.size() > 5) chk("cmd0_crc_byte", mosi_q[5], 9'h095);

        rep = '{8'h01};
        run(6'd8, 32'h000001AA, 1'b0, rep, 1'b0);
        if (mosi_q.size() > 5) chk("cmd8_crc_byte", mosi_q[5], 9'h087);

        rep = {};
        run(6'd55, 32'h12345678, 1'b0, rep, 1'b0);

        rep = '{8'h00, 8'hFF, 8'hFF, 8'hFE};
        for (int i = 0; i < BLOCK_BYTES; i++) rep.push_back(8'(i));
        rep.push_back(8'h3C); rep.push_back(8'hA5);
        run(6'd17, 32'h00000010, 1'b1, rep, 1'b1);

        rep = '{8'h00, 8'hFF, 8'hFF, 8'h05};
        run(6'd17, 32'h00000010, 1'b1, rep, 1'b0);

        rep = '{8'h00};
        run(6'd17, 32'h00000200, 1'b1, rep, 1'b0);

        for (int t = 0; t < 8; t++) begin
            rep = {};
            repeat ($urandom_range(0, 9)) rep.push_back(8'($urandom_range(128, 255)));
            v  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
            rep.push_back(v);
            rr = 1'($urandom);
            if (t < 3) rr = 1'b1;
            repeat ($urandom_range(0, 5)) begin
                v = 8'($urandom_range(16, 255));
                rep.push_back(v == 8'hFE ? 8'hFF : v);
            end
            case ($urandom_range(0, 2))
                0: rep.push_back(8'($urandom_range(0, 15)));
                default: rep.push_back(8'hFE);
            endcase
            for (int i = 0; i < BLOCK_BYTES + 2; i++) rep.push_back(8'($urandom));
            run(6'($urandom), $urandom, rr, rep, 1'($urandom));
        end

        // block read aborted by reset at byte 100
        resp_q = {};
        repeat (6) resp_q.push_back(8'hFF);
        resp_q.push_back(8'h00);
        resp_q.push_back(8'hFE);
        for (int i = 0; i < BLOCK_BYTES; i++) resp_q.push_back(8'(i));
        mosi_q = {}; dq = {}; done_cnt = 0;
        @(negedge clk);
        start = 1'b1; cmd = 6'd17; arg = 32'h10; rd = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (dq.size() < 100 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", dq.size() >= 100, 1'b1);
        if (dq.size() > 99) chk("abort_byte99", dq[99], 8'd99);
        chk("abort_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        repeat (8) @(negedge clk);
        chk_reset_vals("held_reset");
        chk("abort_no_done", done_cnt, 0);
        resp_q = {};
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle_busy", busy, 1'b0);

        rep = '{8'hFF, 8'hFF, 8'h01};
        run(6'd0, 32'h0, 1'b0, rep, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
